// File: rtl/dbus_pkg.sv
// Shared encodings and the registered memory-request record for the data-bus arbiter.
package dbus_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CORE = 2'd1;
    localparam logic [1:0] AUX  = 2'd2;

    localparam logic [2:0] LEN_B = 3'b001;
    localparam logic [2:0] LEN_H = 3'b010;
    localparam logic [2:0] LEN_W = 3'b100;

    typedef struct packed {
        logic        das;
        logic        drd;
        logic        dwr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } mreq_t;

    function automatic mreq_t mk_req(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [2:0]  len
    );
        mreq_t r;
        r.das  = 1'b1;
        r.drd  = rd;
        r.dwr  = wr;
        r.addr = addr;
        r.data = data;
        r.len  = len;
        return r;
    endfunction

endpackage

// File: rtl/dbus_wait_timer.sv
// Counts cycles spent in a granted state; flags the last cycle before an access is aborted.
module dbus_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RESN,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [7:0] wait_cnt;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN)     wait_cnt <= '0;
        else if (clr)  wait_cnt <= '0;
        else if (en)   wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout = (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates the data-memory port between the core MEM stage and an aux master,
// with starvation protection for aux and a wait timeout on every access.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        C_DAS,
    input  logic        C_DRD,
    input  logic        C_DWR,
    input  logic [31:0] C_DADDR,
    input  logic [31:0] C_DATAO,
    input  logic [2:0]  C_DLEN,
    output logic [31:0] C_DATAI,
    output logic        C_HLT,
    input  logic        A_REQ,
    input  logic        A_WR,
    input  logic [31:0] A_ADDR,
    input  logic [31:0] A_WDATA,
    input  logic [2:0]  A_LEN,
    output logic        A_ACK,
    output logic [31:0] A_RDATA,
    output logic        M_DAS,
    output logic        M_DRD,
    output logic        M_DWR,
    output logic [31:0] M_DADDR,
    output logic [31:0] M_DATAO,
    output logic [2:0]  M_DLEN,
    input  logic [31:0] M_DATAI,
    input  logic        M_RDY,
    output logic        BUS_ERR
);

    logic [1:0] state, state_nxt;
    logic [3:0] starve_cnt;
    logic       busy, timeout, done;
    logic       grant_core, grant_aux;
    mreq_t      mreq;

    assign busy       = (state == CORE) || (state == AUX);
    assign done       = busy && (M_RDY || timeout);
    assign grant_core = (state == IDLE) && (state_nxt == CORE);
    assign grant_aux  = (state == IDLE) && (state_nxt == AUX);

    dbus_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .CLK     (CLK),
        .RESN    (RESN),
        .clr     (done),
        .en      (busy),
        .timeout (timeout)
    );

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Starved aux beats the core; otherwise the core has priority.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (A_REQ && (starve_cnt >= 4'(STARVE_MAX))) state_nxt = AUX;
                else if (C_DAS)                              state_nxt = CORE;
                else if (A_REQ)                              state_nxt = AUX;
            end
            CORE, AUX: if (done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        C_HLT   = !RESN || (C_DAS && !((state == CORE) && done));
        A_ACK   = (state == AUX) && done;
        BUS_ERR = done && !M_RDY;
        C_DATAI = ((state == CORE) && M_RDY) ? M_DATAI : '0;
        A_RDATA = ((state == AUX)  && M_RDY) ? M_DATAI : '0;
    end

    // Winner's request is captured on the grant edge and held until completion.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN)           mreq <= '0;
        else if (done)       mreq <= '0;
        else if (grant_core) mreq <= mk_req(C_DRD, C_DWR, C_DADDR, C_DATAO, C_DLEN);
        else if (grant_aux)  mreq <= mk_req(!A_WR, A_WR, A_ADDR, A_WDATA, A_LEN);
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN)
            starve_cnt <= '0;
        else if (grant_aux)
            starve_cnt <= '0;
        else if (A_REQ && (state != AUX) && (starve_cnt != 4'hF))
            starve_cnt <= starve_cnt + 4'd1;
    end

    assign M_DAS   = mreq.das;
    assign M_DRD   = mreq.drd;
    assign M_DWR   = mreq.dwr;
    assign M_DADDR = mreq.addr;
    assign M_DATAO = mreq.data;
    assign M_DLEN  = mreq.len;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a transaction-level model.
module tb_dbus_arbiter;
    import dbus_pkg::*;

    localparam int SM = 4;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RESN = 1'b0;
    logic        C_DAS, C_DRD, C_DWR;
    logic [31:0] C_DADDR, C_DATAO, C_DATAI;
    logic [2:0]  C_DLEN;
    logic        C_HLT;
    logic        A_REQ, A_WR, A_ACK;
    logic [31:0] A_ADDR, A_WDATA, A_RDATA;
    logic [2:0]  A_LEN;
    logic        M_DAS, M_DRD, M_DWR, M_RDY, BUS_ERR;
    logic [31:0] M_DADDR, M_DATAO, M_DATAI;
    logic [2:0]  M_DLEN;

    int checks = 0;
    int passes = 0;

    always #5 CLK = ~CLK;

    dbus_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESN(RESN),
        .C_DAS(C_DAS), .C_DRD(C_DRD), .C_DWR(C_DWR), .C_DADDR(C_DADDR),
        .C_DATAO(C_DATAO), .C_DLEN(C_DLEN), .C_DATAI(C_DATAI), .C_HLT(C_HLT),
        .A_REQ(A_REQ), .A_WR(A_WR), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_LEN(A_LEN), .A_ACK(A_ACK), .A_RDATA(A_RDATA),
        .M_DAS(M_DAS), .M_DRD(M_DRD), .M_DWR(M_DWR), .M_DADDR(M_DADDR),
        .M_DATAO(M_DATAO), .M_DLEN(M_DLEN), .M_DATAI(M_DATAI), .M_RDY(M_RDY),
        .BUS_ERR(BUS_ERR)
    );

    // Model: who owns the port (0 none, 1 core, 2 aux), how long, and what it asked for.
    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } txn_t;

    int   m_own, m_age, m_starve;
    txn_t m_txn;
    bit   m_core_done, m_aux_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_own = 0; m_age = 0; m_starve = 0;
        m_txn = '{0, 0, 32'd0, 32'd0, 3'd0};
        m_core_done = 0; m_aux_ack = 0;
    endtask

    function automatic bit m_done();
        return (m_own != 0) && ((M_RDY === 1'b1) || (m_age == TO - 1));
    endfunction

    task automatic model_check();
        bit d;
        d = m_done();
        chk("C_HLT",   C_HLT,   !RESN || (C_DAS && !(m_own == 1 && d)));
        chk("A_ACK",   A_ACK,   m_own == 2 && d);
        chk("BUS_ERR", BUS_ERR, d && !M_RDY);
        chk("C_DATAI", C_DATAI, (m_own == 1 && M_RDY) ? M_DATAI : 32'd0);
        chk("A_RDATA", A_RDATA, (m_own == 2 && M_RDY) ? M_DATAI : 32'd0);
        chk("M_DAS",   M_DAS,   m_own != 0);
        chk("M_DRD",   M_DRD,   m_own != 0 && m_txn.rd);
        chk("M_DWR",   M_DWR,   m_own != 0 && m_txn.wr);
        chk("M_DADDR", M_DADDR, (m_own != 0) ? m_txn.addr : 32'd0);
        chk("M_DATAO", M_DATAO, (m_own != 0) ? m_txn.data : 32'd0);
        chk("M_DLEN",  M_DLEN,  (m_own != 0) ? {29'd0, m_txn.len} : 32'd0);
    endtask

    task automatic model_advance();
        bit d, ag;
        int s, o;
        d = m_done();
        s = m_starve;
        o = m_own;
        ag = 0;
        m_core_done = (o == 1) && d;
        m_aux_ack   = (o == 2) && d;
        if (!RESN) begin
            model_reset();
            return;
        end
        if (o != 0) begin
            if (d) begin m_own = 0; m_age = 0; end
            else m_age++;
        end else if (A_REQ && s >= SM) ag = 1;
        else if (C_DAS) begin
            m_own = 1; m_age = 0;
            m_txn = '{C_DRD, C_DWR, C_DADDR, C_DATAO, C_DLEN};
        end else if (A_REQ) ag = 1;
        if (ag) begin
            m_own = 2; m_age = 0; m_starve = 0;
            m_txn = '{!A_WR, A_WR, A_ADDR, A_WDATA, A_LEN};
        end else if (A_REQ && o != 2) m_starve = (s < 15) ? s + 1 : 15;
    endtask

    task automatic step();
        @(negedge CLK);
        model_check();
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        C_DAS = 0; C_DRD = 0; C_DWR = 0; C_DADDR = '0; C_DATAO = '0; C_DLEN = '0;
        A_REQ = 0; A_WR = 0; A_ADDR = '0; A_WDATA = '0; A_LEN = '0;
        M_RDY = 0; M_DATAI = '0;
    endtask

    initial begin
        int hlt_cnt, ack_at, core_grants, stall;
        logic [2:0] lens [3];
        lens = '{LEN_B, LEN_H, LEN_W};
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_m_das", M_DAS, 0);
        chk("rst_c_hlt", C_HLT, 1);
        chk("rst_a_ack", A_ACK, 0);
        chk("rst_bus_err", BUS_ERR, 0);
        step();
        RESN = 1;
        step();

        // Core load, ready on first granted cycle
        C_DAS = 1; C_DRD = 1; C_DADDR = 32'h100; C_DLEN = LEN_W;
        #1 chk("t1_hlt_req", C_HLT, 1);
        step();
        M_RDY = 1; M_DATAI = 32'h12345678;
        #1;
        chk("t1_das", M_DAS, 1);
        chk("t1_addr", M_DADDR, 32'h100);
        chk("t1_hlt_rel", C_HLT, 0);
        chk("t1_rdata", C_DATAI, 32'h12345678);
        step();
        idle_inputs();
        #1 chk("t1_das_off", M_DAS, 0);
        step();

        // Core store, ready delayed 3 cycles
        C_DAS = 1; C_DWR = 1; C_DADDR = 32'h204; C_DATAO = 32'hCAFEF00D; C_DLEN = LEN_W;
        hlt_cnt = 0;
        for (int k = 0; k <= 4; k++) begin
            M_RDY = (k == 4);
            #1;
            if (C_HLT) hlt_cnt++;
            if (k > 0) begin
                chk("t2_dwr", M_DWR, 1);
                chk("t2_wdata", M_DATAO, 32'hCAFEF00D);
            end
            step();
        end
        chk("t2_hlt_cycles", hlt_cnt, 4);
        idle_inputs();
        step();

        // Simultaneous requests, no starvation: core first, aux after the gap
        C_DAS = 1; C_DRD = 1; C_DADDR = 32'h300; C_DLEN = LEN_H;
        A_REQ = 1; A_WR = 1; A_ADDR = 32'h400; A_WDATA = 32'h55AA55AA; A_LEN = LEN_B;
        step();
        M_RDY = 1;
        #1;
        chk("t3_core_first", M_DADDR, 32'h300);
        chk("t3_no_ack", A_ACK, 0);
        step();
        C_DAS = 0; M_RDY = 0;
        #1 chk("t3_gap", M_DAS, 0);
        step();
        M_RDY = 1;
        #1;
        chk("t3_aux_addr", M_DADDR, 32'h400);
        chk("t3_aux_wr", M_DWR, 1);
        chk("t3_aux_wdata", M_DATAO, 32'h55AA55AA);
        chk("t3_ack", A_ACK, 1);
        step();
        A_REQ = 0; M_RDY = 0;
        #1 chk("t3_ack_once", A_ACK, 0);
        step();

        // Back-to-back core traffic starves aux until forced grant
        C_DAS = 1; C_DRD = 1; C_DWR = 0; C_DADDR = 32'h500; C_DLEN = LEN_W;
        A_REQ = 1; A_WR = 0; A_ADDR = 32'h600; A_LEN = LEN_W;
        M_RDY = 1; M_DATAI = 32'h0BADCAFE;
        ack_at = -1; core_grants = 0;
        for (int k = 0; k < 8 && ack_at < 0; k++) begin
            #1;
            if (M_DAS && M_DADDR == 32'h500) core_grants++;
            if (A_ACK) ack_at = k;
            step();
        end
        chk("t4_ack_cycle", ack_at, 5);
        chk("t4_core_grants", core_grants, 2);
        A_REQ = 0;
        #1 chk("t4_ack_drop", A_ACK, 0);
        step();
        A_REQ = 1;
        #1 chk("t4_core_after", M_DADDR, 32'h500);
        step();
        step();
        #1 chk("t4_starve_cleared", M_DADDR, 32'h500);
        idle_inputs();
        M_RDY = 1;
        step();
        M_RDY = 0;
        step();

        // Aux read that never gets ready: timeout abort
        A_REQ = 1; A_WR = 0; A_ADDR = 32'h700; A_LEN = LEN_W; M_DATAI = 32'hDEADBEEF;
        step();
        ack_at = -1;
        for (int g = 1; g <= 20 && ack_at < 0; g++) begin
            #1;
            if (A_ACK) begin
                ack_at = g;
                chk("t5_err", BUS_ERR, 1);
                chk("t5_rdata", A_RDATA, 0);
            end
            step();
        end
        chk("t5_ack_cycle", ack_at, 16);
        A_REQ = 0;
        step();

        // Reset in the middle of a core wait
        C_DAS = 1; C_DWR = 1; C_DADDR = 32'h800; C_DATAO = 32'h11112222; C_DLEN = LEN_W;
        step();
        step();
        RESN = 0;
        #1;
        chk("t6_das", M_DAS, 0);
        chk("t6_dwr", M_DWR, 0);
        chk("t6_addr", M_DADDR, 0);
        chk("t6_hlt", C_HLT, 1);
        chk("t6_err", BUS_ERR, 0);
        model_reset();
        step();
        RESN = 1;
        step();
        M_RDY = 1;
        #1;
        chk("t6_regrant", M_DADDR, 32'h800);
        chk("t6_regrant_das", M_DAS, 1);
        step();
        idle_inputs();
        step();

        // Random traffic
        stall = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_core_done) C_DAS = 0;
            if (!C_DAS && $urandom_range(99) < 35) begin
                C_DAS = 1;
                C_DRD = 1'($urandom_range(1));
                C_DWR = !C_DRD;
                C_DADDR = $urandom;
                C_DATAO = $urandom;
                C_DLEN = lens[$urandom_range(2)];
            end
            if (m_aux_ack) A_REQ = 0;
            else if (!A_REQ && $urandom_range(99) < 25) begin
                A_REQ = 1;
                A_WR = 1'($urandom_range(1));
                A_ADDR = $urandom;
                A_WDATA = $urandom;
                A_LEN = lens[$urandom_range(2)];
            end
            if (stall > 0) begin
                stall--;
                M_RDY = 0;
            end else begin
                if ($urandom_range(99) < 2) stall = 20;
                M_RDY = ($urandom_range(99) < 45);
            end
            M_DATAI = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Arbitrates the single data-memory port between two masters: the core's MEM-stage data request and an auxiliary master (debug or DMA).
- Sequences each access with a ready handshake and a timeout.
- Holds the core pipeline via C_HLT until the core's access completes.
- Sits between the core's memory stage and the data RAM/IO bus.

Parameters:
- STARVE_MAX, 4, consecutive cycles the aux request may be pending and ungranted before it gets forced priority (1..15).
- TIMEOUT, 16, wait cycles in a granted state without M_RDY before the access is aborted (2..255).

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESN  in  1  asynchronous active-low reset
- C_DAS  in  1  core access strobe (load or store)
- C_DRD  in  1  core read
- C_DWR  in  1  core write
- C_DADDR  in  32  core address
- C_DATAO  in  32  core write data
- C_DLEN  in  3  core size: 001 byte, 010 half, 100 word
- C_DATAI  out  32  read data to core
- C_HLT  out  1  pipeline hold
- A_REQ  in  1  aux request, level; held with stable fields until A_ACK
- A_WR  in  1  aux write (0 = read)
- A_ADDR  in  32  aux address
- A_WDATA  in  32  aux write data
- A_LEN  in  3  aux size, same encoding as C_DLEN
- A_ACK  out  1  aux completion pulse
- A_RDATA  out  32  aux read data, valid with A_ACK
- M_DAS, M_DRD, M_DWR  out  1 each  memory strobes (registered)
- M_DADDR  out  32  memory address (registered)
- M_DATAO  out  32  memory write data (registered)
- M_DLEN  out  3  memory size (registered)
- M_DATAI  in  32  memory read data
- M_RDY  in  1  memory completes the current access this cycle
- BUS_ERR  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (RESN low, asynchronous): state IDLE, starve_cnt=0, wait_cnt=0, all M_* outputs 0, A_ACK=0, BUS_ERR=0, C_HLT=1.
- States: IDLE, CORE, AUX.
- Arbitration in IDLE:
  - A_REQ && starve_cnt>=STARVE_MAX -> AUX.
  - else C_DAS -> CORE.
  - else A_REQ -> AUX.
  - else stay IDLE.
- On any grant: latch the winner's address, data, length and read/write into the M_* registers at the same edge; M_DAS=1 from the first granted cycle.
- In CORE or AUX:
  - wait_cnt increments each cycle.
  - Done condition = M_RDY || wait_cnt==TIMEOUT-1.
  - On done: next state IDLE, M_* cleared at the edge, wait_cnt cleared.
- Timeout (done without M_RDY): BUS_ERR=1 for that cycle; returned read data is 0; writes are dropped silently.
- C_HLT (combinational) = C_DAS && !(state==CORE && done). A core access is therefore at least 2 cycles: request cycle, then the granted cycle with M_RDY.
- C_DATAI = M_DATAI when state==CORE && M_RDY, otherwise 0.
- A_ACK (combinational) = state==AUX && done. A_RDATA follows the same rule as C_DATAI. Aux must drop A_REQ the cycle after A_ACK; if still high, it counts as a new request.
- starve_cnt:
  - increments (saturating at 15) each cycle A_REQ is high and state!=AUX;
  - clears on entry to AUX.
- Back-to-back: completion returns to IDLE for exactly one cycle; no same-cycle re-grant.
- Simultaneous C_DAS and A_REQ with starve_cnt<STARVE_MAX: core wins.
- C_DAS dropping while in CORE is a protocol violation; the access still completes.
- Reset mid-access aborts it with no ACK and no BUS_ERR.

Decomposition:
- Shared package dbus_pkg holds:
  - state encoding localparams (IDLE=2'd0, CORE=2'd1, AUX=2'd2);
  - DLEN encodings (LEN_B=3'b001, LEN_H=3'b010, LEN_W=3'b100).
- One natural sub-module: dbus_wait_timer. It holds wait_cnt with clear/enable inputs and emits the timeout flag.

Test Plan:
- Core load, C_DADDR=0x100, M_RDY high in first granted cycle, M_DATAI=0x12345678 -> C_HLT high 1 cycle, M_DAS high 1 cycle, C_DATAI=0x12345678 on release.
- Core store with M_RDY delayed 3 cycles, C_DATAO=0xCAFEF00D, C_DLEN=100 -> C_HLT high 4 cycles; M_DWR=1 and M_DATAO=0xCAFEF00D held stable throughout.
- C_DAS and A_REQ in the same cycle, starve_cnt=0 -> CORE granted first; AUX granted after the 1-cycle IDLE gap; A_ACK pulses once.
- Core issues continuous back-to-back requests while A_REQ stays high, STARVE_MAX=4 -> AUX forcibly granted once starve_cnt reaches 4; starve_cnt returns to 0.
- Aux read with M_RDY never asserted, TIMEOUT=16 -> A_ACK and BUS_ERR pulse together on the 16th granted cycle; A_RDATA=0.
- RESN pulled low during a CORE wait -> all M_* go to 0 immediately and C_HLT=1; after release, state is IDLE and the next C_DAS is granted normally.
